vbank_wr_sched: RTL and testbench
=================================

# vbank_wr_sched

Write-port scheduler for the multi-lane vector register bank. Two producers (requester 0: vector ALU writeback, requester 1: memory load unit) share the bank's single write port (`we`, `wd1..wd4`). The block arbitrates between them, locks the port for a whole multi-beat vector burst, and drives registered write strobes, register index and beat index into the bank. It sits between the execute/memory stages and the vector bank in the decode/register-file area.

## Interface
- `LANES`, 4: 32-bit words written per beat (matches bank `wd1..wd4`).
- `NREG`, 8: vector registers in the bank; address width is `$clog2(NREG)`.
- `BEATS`, 2: maximum beats per vector burst; beat index width is `$clog2(BEATS)`, minimum 1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s0_valid`, `s1_valid`  in  1  requester has a beat to write.
- `s0_ready`, `s1_ready`  out  1  beat accepted this cycle when valid&ready.
- `s0_addr`, `s1_addr`  in  `$clog2(NREG)`  destination vector register; sampled only in the arbitration cycle.
- `s0_data`, `s1_data`  in  `32*LANES`  beat data; lane 0 is bits [31:0].
- `s0_last`, `s1_last`  in  1  final beat of the burst.
- `bank_we`  out  1  write strobe to bank.
- `bank_waddr`  out  `$clog2(NREG)`  register index.
- `bank_wbeat`  out  `$clog2(BEATS)`  beat (lane group) index.
- `bank_wd`  out  `32*LANES`  write data.
- `done0`, `done1`  out  1  one-cycle pulse coincident with the final `bank_we` of that requester's burst.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, BURST0, BURST1. Reset: IDLE, priority pointer = 0, beat counter = 0.
- IDLE: `s0_ready` = `s1_ready` = 0. If any valid, the winner is chosen: the only valid requester, or if both are valid, the requester selected by the priority pointer. Next state is BURSTn. The winner's `sN_addr` is latched.
- BURSTn: `sN_ready` = 1 and the other ready = 0. The other requester's valid is ignored.
- Each transfer (`sN_valid` & `sN_ready`) writes one beat at the latched address with `bank_wbeat` = beat counter. The beat counter then increments.
- A burst ends on a transfer with `sN_last` = 1, or on a transfer when the beat counter = BEATS-1. This forced end happens even if `last` = 0.
- At burst end: next state IDLE, beat counter := 0, pointer := other requester (round-robin), and `doneN` pulses.
- Valid deasserted mid-burst: stay in BURSTn, hold the counter, no write. There is no timeout.
- `rst` mid-burst: return to IDLE with all outputs 0. The beats already written stay in the bank (no rollback), and no `done` pulse is issued.
- `bank_*` outputs and `done*` are registered. Their reset value is 0. `busy` is decoded from state and is 0 in reset.

## Timing
- Arbitration costs 1 cycle: a valid seen in IDLE at edge k gives ready = 1 during cycle k+1.
- Write latency is 1 cycle: a transfer in cycle t produces `bank_we` = 1 with that data, address and beat in cycle t+1. The bank captures it at the edge that ends t+1.
- Throughput is 1 beat/cycle within a burst. A 2-beat burst occupies 3 cycles (IDLE + 2).
- Back-to-back bursts leave one idle port cycle between them, because the FSM passes through IDLE.
- `bank_we` is 0 in every cycle that did not follow a transfer.

## Configuration
- `VBANK_SCHED_RR_EN` defined: round-robin priority. After each completed burst the pointer moves to the other requester.
- Not defined: fixed priority. Requester 0 always wins a tie, the pointer register is not built, and requester 1 can starve.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold `rst` 2 cycles with both valids high -> `bank_we` = 0, `busy` = 0, both readies 0, `done*` = 0.
- Single 2-beat burst: `s0_addr` = 3, beats {15,45,74,82} then {16,46,75,83}, last on beat 1 -> `bank_we` for 2 cycles with waddr 3, wbeat 0 then 1, matching data, `done0` on the second, `busy` returns to 0.
- Contention: both valid from IDLE with addr 1 and 5 -> requester 0 is served first. Then, with RR_EN, requester 1 is served next; without RR_EN and s0 still valid, requester 0 is served again.
- Stall: `s1_valid` drops for 3 cycles between beat 0 and beat 1 -> no `bank_we` during the gap, wbeat resumes at 1, `s0_ready` stays 0 throughout.
- Forced end: s0 sends 2 beats with `last` = 0 -> the burst closes after beat 1 with `done0` = 1, and the FSM returns to IDLE.
- Reset mid-burst: assert `rst` after beat 0 -> next cycle `bank_we` = 0, `busy` = 0, no `done0`, and a new request re-arbitrates from beat 0.

Source files
------------

// File: rtl/vbank_wr_sched.sv
// rtl/vbank_wr_sched.sv - two-requester write-port scheduler for the vector register bank
// Build option: define VBANK_SCHED_RR_EN for round-robin tie-break; otherwise requester 0 always wins.
module vbank_wr_sched #(
    parameter int LANES = 4,
    parameter int NREG  = 8,
    parameter int BEATS = 2,
    localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [AW-1:0]         s0_addr,
    input  logic [32*LANES-1:0]   s0_data,
    input  logic                  s0_last,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [AW-1:0]         s1_addr,
    input  logic [32*LANES-1:0]   s1_data,
    input  logic                  s1_last,
    output logic                  bank_we,
    output logic [AW-1:0]         bank_waddr,
    output logic [BW-1:0]         bank_wbeat,
    output logic [32*LANES-1:0]   bank_wd,
    output logic                  done0,
    output logic                  done1,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, BURST0, BURST1} state_t;

    state_t               state, state_nxt;
    logic [AW-1:0]        addr_q, addr_nxt;
    logic [BW-1:0]        beat_q, beat_nxt;
    logic                 xfer;
    logic                 end0, end1;
    logic                 pick1;
    logic                 beat_max;
    logic [32*LANES-1:0]  data_sel;

`ifdef VBANK_SCHED_RR_EN
    logic ptr;

    always_ff @(posedge clk) begin
        if (rst)       ptr <= 1'b0;
        else if (end0) ptr <= 1'b1;
        else if (end1) ptr <= 1'b0;
    end

    assign pick1 = ptr;
`else
    assign pick1 = 1'b0;
`endif

    assign beat_max = (beat_q == BW'(BEATS - 1));
    assign s0_ready = (state == BURST0) && !rst;
    assign s1_ready = (state == BURST1) && !rst;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        beat_nxt  = beat_q;
        xfer      = 1'b0;
        end0      = 1'b0;
        end1      = 1'b0;
        data_sel  = s0_data;
        case (state)
            IDLE: begin
                if (s0_valid && s1_valid) begin
                    state_nxt = pick1 ? BURST1 : BURST0;
                    addr_nxt  = pick1 ? s1_addr : s0_addr;
                end else if (s0_valid) begin
                    state_nxt = BURST0;
                    addr_nxt  = s0_addr;
                end else if (s1_valid) begin
                    state_nxt = BURST1;
                    addr_nxt  = s1_addr;
                end
            end
            BURST0: begin
                xfer     = s0_valid;
                data_sel = s0_data;
                if (s0_valid) begin
                    // Burst closes on last or when the beat counter would wrap.
                    if (s0_last || beat_max) begin
                        end0      = 1'b1;
                        state_nxt = IDLE;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat_q + BW'(1);
                    end
                end
            end
            BURST1: begin
                xfer     = s1_valid;
                data_sel = s1_data;
                if (s1_valid) begin
                    if (s1_last || beat_max) begin
                        end1      = 1'b1;
                        state_nxt = IDLE;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat_q + BW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            beat_q <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            beat_q <= beat_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_we    <= 1'b0;
            bank_waddr <= '0;
            bank_wbeat <= '0;
            bank_wd    <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
        end else begin
            bank_we <= xfer;
            done0   <= end0;
            done1   <= end1;
            if (xfer) begin
                bank_waddr <= addr_q;
                bank_wbeat <= beat_q;
                bank_wd    <= data_sel;
            end
        end
    end

endmodule

// File: tb/tb_vbank_wr_sched.sv
// tb/tb_vbank_wr_sched.sv - directed bench with cycle model for vbank_wr_sched
module tb_vbank_wr_sched;

    localparam int LANES = 4;
    localparam int NREG  = 8;
    localparam int BEATS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         s0_valid, s1_valid, s0_last, s1_last;
    logic         s0_ready, s1_ready;
    logic [2:0]   s0_addr, s1_addr;
    logic [127:0] s0_data, s1_data;
    logic         bank_we, done0, done1, busy;
    logic [2:0]   bank_waddr;
    logic [0:0]   bank_wbeat;
    logic [127:0] bank_wd;

    int errors = 0;
    int checks = 0;

    vbank_wr_sched #(.LANES(LANES), .NREG(NREG), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr),
        .s0_data(s0_data), .s0_last(s0_last),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr),
        .s1_data(s1_data), .s1_last(s1_last),
        .bank_we(bank_we), .bank_waddr(bank_waddr), .bank_wbeat(bank_wbeat),
        .bank_wd(bank_wd), .done0(done0), .done1(done1), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] pack(input int a, input int b, input int c, input int d);
        return {d[31:0], c[31:0], b[31:0], a[31:0]};
    endfunction

    // Model: who owns the port, how many beats it has written, and the tie-break pointer.
    int           m_owner = -1;
    int           m_beat  = 0;
    int           m_ptr   = 0;
    int           m_addr  = 0;
    bit           started = 0;
    logic         e_we = 0, e_d0 = 0, e_d1 = 0;
    int           e_addr = 0, e_beat = 0;
    logic [127:0] e_wd = '0;

    always @(posedge clk) begin : model
        int  win;
        bit  v, l;
        started <= 1'b1;
        e_we <= 1'b0;
        e_d0 <= 1'b0;
        e_d1 <= 1'b0;
        if (rst) begin
            m_owner <= -1;
            m_beat  <= 0;
            m_ptr   <= 0;
        end else if (m_owner < 0) begin
            win = -1;
            if (s0_valid && s1_valid) begin
`ifdef VBANK_SCHED_RR_EN
                win = m_ptr;
`else
                win = 0;
`endif
            end else if (s0_valid) win = 0;
            else if (s1_valid) win = 1;
            if (win >= 0) begin
                m_owner <= win;
                m_addr  <= (win == 1) ? int'(s1_addr) : int'(s0_addr);
            end
        end else begin
            v = (m_owner == 1) ? s1_valid : s0_valid;
            l = (m_owner == 1) ? s1_last : s0_last;
            if (v) begin
                e_we   <= 1'b1;
                e_addr <= m_addr;
                e_beat <= m_beat;
                e_wd   <= (m_owner == 1) ? s1_data : s0_data;
                if (l || m_beat == BEATS - 1) begin
                    e_d0    <= (m_owner == 0);
                    e_d1    <= (m_owner == 1);
                    m_owner <= -1;
                    m_beat  <= 0;
                    m_ptr   <= 1 - m_owner;
                end else begin
                    m_beat <= m_beat + 1;
                end
            end
        end
    end

    typedef struct {
        int           addr;
        int           beat;
        logic [127:0] wd;
        logic         d0;
        logic         d1;
    } wr_t;
    wr_t log_q[$];

    always @(negedge clk) begin : compare
        if (started) begin
            check("s0_ready", s0_ready, (m_owner == 0) && !rst);
            check("s1_ready", s1_ready, (m_owner == 1) && !rst);
            check("busy", busy, m_owner >= 0);
            check("bank_we", bank_we, e_we);
            check("done0", done0, e_d0);
            check("done1", done1, e_d1);
            if (e_we) begin
                check("bank_waddr", bank_waddr, e_addr[2:0]);
                check("bank_wbeat", bank_wbeat, e_beat[0:0]);
                check("bank_wd", bank_wd, e_wd);
            end
        end
        if (bank_we === 1'b1)
            log_q.push_back('{int'(bank_waddr), int'(bank_wbeat), bank_wd, done0, done1});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_beat(input int n, input logic [127:0] d, input logic l);
        int cnt = 0;
        if (n == 0) begin s0_valid = 1'b1; s0_data = d; s0_last = l; end
        else        begin s1_valid = 1'b1; s1_data = d; s1_last = l; end
        while (((n == 0) ? s0_ready : s1_ready) !== 1'b1 && cnt < 20) begin
            tick(1);
            cnt++;
        end
        checks++;
        if (cnt >= 20) begin
            errors++;
            $display("FAIL handshake_timeout req%0d: waited %0d cycles, limit 20", n, cnt);
        end
        tick(1);
        if (n == 0) s0_valid = 1'b0;
        else        s1_valid = 1'b0;
    endtask

    task automatic do_reset();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic check_log(input string name, input int idx, input int addr, input int beat,
                             input logic [127:0] wd, input logic d0, input logic d1);
        checks++;
        if (idx >= log_q.size()) begin
            errors++;
            $display("FAIL %s: write %0d missing, got %0d writes", name, idx, log_q.size());
        end else begin
            check({name, "_addr"}, log_q[idx].addr, addr);
            check({name, "_beat"}, log_q[idx].beat, beat);
            check({name, "_wd"}, log_q[idx].wd, wd);
            check({name, "_done0"}, log_q[idx].d0, d0);
            check({name, "_done1"}, log_q[idx].d1, d1);
        end
    endtask

    initial begin
        rst = 1'b1;
        s0_valid = 1'b1; s1_valid = 1'b1;
        s0_last = 1'b0;  s1_last = 1'b0;
        s0_addr = 3'd0;  s1_addr = 3'd0;
        s0_data = '0;    s1_data = '0;

        tick(2);
        check("rst_bank_we", bank_we, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_s0_ready", s0_ready, 1'b0);
        check("rst_s1_ready", s1_ready, 1'b0);
        check("rst_done", {done0, done1}, 2'b00);
        do_reset();

        // Single 2-beat burst from requester 0.
        s0_addr = 3'd3;
        send_beat(0, pack(15, 45, 74, 82), 1'b0);
        send_beat(0, pack(16, 46, 75, 83), 1'b1);
        tick(3);
        check("single_busy_after", busy, 1'b0);
        check("single_count", log_q.size(), 2);
        check_log("single_b0", 0, 3, 0, pack(15, 45, 74, 82), 1'b0, 1'b0);
        check_log("single_b1", 1, 3, 1, pack(16, 46, 75, 83), 1'b1, 1'b0);
        do_reset();

        // Contention: both single-beat requests held from IDLE.
        s0_addr = 3'd1; s0_data = pack(1, 2, 3, 4); s0_last = 1'b1;
        s1_addr = 3'd5; s1_data = pack(9, 8, 7, 6); s1_last = 1'b1;
        s0_valid = 1'b1; s1_valid = 1'b1;
        tick(6);
        s0_valid = 1'b0; s1_valid = 1'b0;
        check_log("cont_first", 0, 1, 0, pack(1, 2, 3, 4), 1'b1, 1'b0);
`ifdef VBANK_SCHED_RR_EN
        check_log("cont_second", 1, 5, 0, pack(9, 8, 7, 6), 1'b0, 1'b1);
`else
        check_log("cont_second", 1, 1, 0, pack(1, 2, 3, 4), 1'b1, 1'b0);
`endif
        do_reset();

        // Stall: requester 1 drops valid for 3 cycles mid-burst while s0 waits.
        s1_addr = 3'd6;
        s0_addr = 3'd2; s0_last = 1'b0;
        send_beat(1, pack(21, 22, 23, 24), 1'b0);
        s0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_s0_ready", s0_ready, 1'b0);
            check("stall_busy", busy, 1'b1);
            tick(1);
        end
        s0_valid = 1'b0;
        send_beat(1, pack(31, 32, 33, 34), 1'b1);
        tick(2);
        check("stall_count", log_q.size(), 2);
        check_log("stall_b0", 0, 6, 0, pack(21, 22, 23, 24), 1'b0, 1'b0);
        check_log("stall_b1", 1, 6, 1, pack(31, 32, 33, 34), 1'b0, 1'b1);
        do_reset();

        // Forced end: two beats without last.
        s0_addr = 3'd2;
        send_beat(0, pack(41, 42, 43, 44), 1'b0);
        send_beat(0, pack(51, 52, 53, 54), 1'b0);
        tick(2);
        check("forced_busy", busy, 1'b0);
        check_log("forced_b1", 1, 2, 1, pack(51, 52, 53, 54), 1'b1, 1'b0);
        do_reset();

        // Reset after beat 0, then a fresh request starts from beat 0.
        s0_addr = 3'd4;
        send_beat(0, pack(61, 62, 63, 64), 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_bank_we", bank_we, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done0", done0, 1'b0);
        s0_addr = 3'd7;
        send_beat(0, pack(71, 72, 73, 74), 1'b1);
        tick(2);
        check("midrst_count", log_q.size(), 2);
        check_log("midrst_b0", 0, 4, 0, pack(61, 62, 63, 64), 1'b0, 1'b0);
        check_log("midrst_new", 1, 7, 0, pack(71, 72, 73, 74), 1'b1, 1'b0);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
